// File: rtl/crv32_pkg.sv
// Shared types and constants for the crv32 memory-bus arbiter and CPU reset sequencer.
package crv32_pkg;

  // Default widths of the SoC memory bus.
  localparam int unsigned CRV32_ADDR_W = 32;
  localparam int unsigned CRV32_DATA_W = 32;

  // Bit value replicated across rdata when a transfer is completed by timeout.
  localparam logic TIMEOUT_RDATA_BIT = 1'b0;

  // Arbiter states: one transfer is IDLE -> XFER_* -> ACK -> IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER_CPU = 2'd1,
    XFER_DBG = 2'd2,
    ACK      = 2'd3
  } arb_state_e;

  // Grant identity, also used as the round-robin memory.
  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_e;

endpackage

// File: rtl/crv32_rst_seq.sv
// CPU reset sequencer: holds cpu_n_reset low while halted, and for RST_HOLD
// cycles after a halt is dropped. A halt that arrives while the CPU owns the
// bus is remembered and applied only once that transfer has been acknowledged.
module crv32_rst_seq
  import crv32_pkg::*;
#(
  parameter int unsigned RST_HOLD = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic dbg_halt,
  input  logic cpu_busy,
  output logic halt_req,
  output logic cpu_n_reset,
  output logic dbg_halted
);

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

  logic       cpu_n_reset_q, cpu_n_reset_d;
  logic       dbg_halted_q, dbg_halted_d;
  logic       halt_pend_q, halt_pend_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // A halt is wanted either now or from a deferred request.
  assign halt_req    = dbg_halt | halt_pend_q;
  assign cpu_n_reset = cpu_n_reset_q;
  assign dbg_halted  = dbg_halted_q;

  // Next-state: defer during CPU transfers, else assert/reload, else count down.
  always_comb begin
    cpu_n_reset_d = cpu_n_reset_q;
    hold_cnt_d    = hold_cnt_q;
    halt_pend_d   = halt_pend_q;
    if (cpu_busy) begin
      if (dbg_halt) begin
        halt_pend_d = 1'b1;
      end
    end else if (halt_req) begin
      cpu_n_reset_d = 1'b0;
      hold_cnt_d    = HOLD_INIT;
      halt_pend_d   = 1'b0;
    end else if (!cpu_n_reset_q) begin
      if (hold_cnt_q <= 8'd1) begin
        cpu_n_reset_d = 1'b1;
        hold_cnt_d    = 8'd0;
      end else begin
        hold_cnt_d = hold_cnt_q - 8'd1;
      end
    end
    dbg_halted_d = ~cpu_n_reset_d;
  end

  // Sequencer registers; reset holds the CPU in reset with a full hold count.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cpu_n_reset_q <= 1'b0;
      dbg_halted_q  <= 1'b1;
      halt_pend_q   <= 1'b0;
      hold_cnt_q    <= HOLD_INIT;
    end else begin
      cpu_n_reset_q <= cpu_n_reset_d;
      dbg_halted_q  <= dbg_halted_d;
      halt_pend_q   <= halt_pend_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/crv32_mem_arb.sv
// Memory-bus arbiter for the crv32 SoC: shares one bus between the picorv32
// native port and the debug port, and owns the CPU reset via crv32_rst_seq.
//
// Handshakes: a requester (cpu_valid / dbg_req) holds its request and payload
// stable until it sees its one-cycle completion pulse (cpu_ready / dbg_ack);
// read data is valid only in that pulse cycle. On the bus side bus_valid and
// bus_addr/wdata/wstrb stay stable until bus_ready is sampled high at a clock
// edge; bus_rdata is captured on that same edge.
module crv32_mem_arb
  import crv32_pkg::*;
#(
  parameter int unsigned ADDR_W   = CRV32_ADDR_W,
  parameter int unsigned DATA_W   = CRV32_DATA_W,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  cpu_valid,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wstrb,
  output logic                  cpu_ready,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_n_reset,
  input  logic                  dbg_halt,
  output logic                  dbg_halted,
  input  logic                  dbg_req,
  input  logic [ADDR_W-1:0]     dbg_adr,
  input  logic [DATA_W-1:0]     dbg_do,
  input  logic [DATA_W/8-1:0]   dbg_wren,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_di,
  output logic                  bus_valid,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_ready,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  bus_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  // The XFER cycle whose count equals this is the last one allowed.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  gnt_e                last_grant_q, last_grant_d;
  logic                bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic                bus_err_q, bus_err_d;

  logic halt_req;
  logic cpu_busy;
  logic cpu_elig;
  logic pick_dbg;

  // The CPU owns the bus from its grant until its ACK cycle has passed.
  assign cpu_busy = (state_q == XFER_CPU) ||
                    ((state_q == ACK) && (last_grant_q == GNT_CPU));

  // The CPU may only be granted while out of reset and with no halt pending.
  assign cpu_elig = cpu_valid & cpu_n_reset & ~halt_req;
  // Debug wins when alone, or when both ask and the CPU was served last.
  assign pick_dbg = dbg_req & (~cpu_elig | (last_grant_q == GNT_CPU));

  crv32_rst_seq #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_seq (
    .clk         (clk),
    .n_reset     (n_reset),
    .dbg_halt    (dbg_halt),
    .cpu_busy    (cpu_busy),
    .halt_req    (halt_req),
    .cpu_n_reset (cpu_n_reset),
    .dbg_halted  (dbg_halted)
  );

  // Arbiter next-state: grant in IDLE, wait for ready or timeout, pulse ack.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus_valid_d  = bus_valid_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    tmo_cnt_d    = tmo_cnt_q;
    rdata_d      = rdata_q;
    cpu_ready_d  = 1'b0;
    dbg_ack_d    = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_elig || dbg_req) begin
          bus_valid_d = 1'b1;
          tmo_cnt_d   = '0;
          if (pick_dbg) begin
            state_d      = XFER_DBG;
            last_grant_d = GNT_DBG;
            bus_addr_d   = dbg_adr;
            bus_wdata_d  = dbg_do;
            bus_wstrb_d  = dbg_wren;
          end else begin
            state_d      = XFER_CPU;
            last_grant_d = GNT_CPU;
            bus_addr_d   = cpu_addr;
            bus_wdata_d  = cpu_wdata;
            bus_wstrb_d  = cpu_wstrb;
          end
        end
      end
      XFER_CPU, XFER_DBG: begin
        if (bus_ready || (tmo_cnt_q == TMO_LAST)) begin
          bus_valid_d = 1'b0;
          state_d     = ACK;
          cpu_ready_d = (last_grant_q == GNT_CPU);
          dbg_ack_d   = (last_grant_q == GNT_DBG);
          if (bus_ready) begin
            rdata_d = bus_rdata;
          end else begin
            rdata_d   = {DATA_W{TIMEOUT_RDATA_BIT}};
            bus_err_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ACK: begin
        // No grant here, so a requester dropping its request now is never re-issued.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter registers; reset abandons any transfer and clears every output.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_CPU;
      bus_valid_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      tmo_cnt_q    <= '0;
      rdata_q      <= '0;
      cpu_ready_q  <= 1'b0;
      dbg_ack_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_valid_q  <= bus_valid_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rdata_q      <= rdata_d;
      cpu_ready_q  <= cpu_ready_d;
      dbg_ack_q    <= dbg_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_err   = bus_err_q;
  assign cpu_ready = cpu_ready_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = rdata_q;
  assign dbg_di    = rdata_q;

endmodule

// File: tb/tb_crv32_mem_arb.sv
// Bench for crv32_mem_arb: scenario tasks drive requests, push expected bus
// and completion values to queues, and compare them when the DUT responds.
module tb_crv32_mem_arb;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int TMO   = 16;
  localparam int HOLD  = 4;
  localparam int SB_W  = 35;  // {dbg_ack, cpu_ready, bus_err, rdata}
  localparam int BUS_W = 68;  // {addr, wdata, wstrb}
  localparam logic [31:0] RD_KEY = 32'h5A5A_1234;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          cpu_valid = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [SW-1:0] cpu_wstrb = '0;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_n_reset;
  logic          dbg_halt = 1'b0;
  logic          dbg_halted;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_adr = '0;
  logic [DW-1:0] dbg_do = '0;
  logic [SW-1:0] dbg_wren = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_di;
  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [SW-1:0] bus_wstrb;
  logic          bus_ready;
  logic [DW-1:0] bus_rdata;
  logic          bus_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int vcnt = 0;
  int ready_delay = 0;
  bit ready_never = 1'b0;

  logic [SB_W-1:0]  exp_q[$];
  logic [BUS_W-1:0] bus_q[$];

  crv32_mem_arb #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RST_HOLD (HOLD),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .cpu_valid   (cpu_valid),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_ready   (cpu_ready),
    .cpu_rdata   (cpu_rdata),
    .cpu_n_reset (cpu_n_reset),
    .dbg_halt    (dbg_halt),
    .dbg_halted  (dbg_halted),
    .dbg_req     (dbg_req),
    .dbg_adr     (dbg_adr),
    .dbg_do      (dbg_do),
    .dbg_wren    (dbg_wren),
    .dbg_ack     (dbg_ack),
    .dbg_di      (dbg_di),
    .bus_valid   (bus_valid),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave model: ready after ready_delay waiting cycles, data keyed on address
  always @(posedge clk) begin
    if (bus_valid && !bus_ready) vcnt <= vcnt + 1;
    else vcnt <= 0;
  end
  assign bus_ready = bus_valid && !ready_never && (vcnt >= ready_delay);
  assign bus_rdata = bus_addr ^ RD_KEY;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SB_W-1:0] ack_exp(bit is_dbg, bit err, logic [31:0] rd);
    return {is_dbg, ~is_dbg, err, rd};
  endfunction

  // Driver-side waits: return what was observed, bounded by a cycle budget
  task automatic wait_bus(output bit got, output logic [BUS_W-1:0] obs);
    got = 1'b0;
    obs = 'x;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_valid === 1'b1) begin
        got = 1'b1;
        obs = {bus_addr, bus_wdata, bus_wstrb};
        break;
      end
    end
  endtask

  task automatic wait_ack(output bit got, output logic [SB_W-1:0] obs, output int at);
    got = 1'b0;
    obs = 'x;
    at  = -1000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_ready === 1'b1 || dbg_ack === 1'b1) begin
        got = 1'b1;
        at  = cyc;
        obs = {dbg_ack, cpu_ready, bus_err, (dbg_ack ? dbg_di : cpu_rdata)};
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic e;
    n_reset = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({bus_valid, cpu_ready, dbg_ack, bus_err, cpu_n_reset, dbg_halted} !== 6'b000001) begin
      n_err++;
      $display("FAIL rst_ctrl: got %b exp 000001",
               {bus_valid, cpu_ready, dbg_ack, bus_err, cpu_n_reset, dbg_halted});
    end
    n_vec++;
    if ({bus_addr, bus_wdata, bus_wstrb, cpu_rdata, dbg_di} !== '0) begin
      n_err++;
      $display("FAIL rst_data: got %h %h %h %h %h exp all 0",
               bus_addr, bus_wdata, bus_wstrb, cpu_rdata, dbg_di);
    end
    n_reset = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      e = (k == HOLD);
      n_vec++;
      if ({cpu_n_reset, dbg_halted} !== {e, ~e}) begin
        n_err++;
        $display("FAIL rst_release edge %0d: got %b exp %b", k, {cpu_n_reset, dbg_halted}, {e, ~e});
      end
    end
  endtask

  task automatic test_arb_priority();
    bit got;
    logic [BUS_W-1:0] bo, be;
    logic [SB_W-1:0] ao, ae;
    int t1, t2;
    logic [31:0] ca, da;
    ca = 32'h0000_0100;
    da = 32'h0002_0010;
    cpu_valid = 1'b1; cpu_addr = ca; cpu_wdata = 32'h1111_2222; cpu_wstrb = 4'h0;
    dbg_req = 1'b1; dbg_adr = da; dbg_do = 32'h3333_4444; dbg_wren = 4'h0;
    bus_q.push_back({da, 32'h3333_4444, 4'h0});
    bus_q.push_back({ca, 32'h1111_2222, 4'h0});
    exp_q.push_back(ack_exp(1'b1, 1'b0, da ^ RD_KEY));
    exp_q.push_back(ack_exp(1'b0, 1'b0, ca ^ RD_KEY));
    wait_bus(got, bo); be = bus_q.pop_front();
    n_vec++;
    if (bo !== be) begin n_err++; $display("FAIL prio_bus_dbg: got %h exp %h", bo, be); end
    wait_ack(got, ao, t1); ae = exp_q.pop_front();
    n_vec++;
    if (ao !== ae) begin n_err++; $display("FAIL prio_ack_dbg: got %h exp %h", ao, ae); end
    dbg_req = 1'b0;
    wait_bus(got, bo); be = bus_q.pop_front();
    n_vec++;
    if (bo !== be) begin n_err++; $display("FAIL prio_bus_cpu: got %h exp %h", bo, be); end
    wait_ack(got, ao, t2); ae = exp_q.pop_front();
    n_vec++;
    if (ao !== ae) begin n_err++; $display("FAIL prio_ack_cpu: got %h exp %h", ao, ae); end
    cpu_valid = 1'b0;
    n_vec++;
    if (t2 - t1 !== 3) begin n_err++; $display("FAIL prio_spacing: got %0d exp 3", t2 - t1); end
    tick();
  endtask

  task automatic test_halt_defer();
    bit got;
    logic [BUS_W-1:0] bo, be;
    logic [SB_W-1:0] ao, ae;
    int g, t;
    ready_delay = 5;
    cpu_valid = 1'b1; cpu_addr = 32'h0002_0000; cpu_wdata = '0; cpu_wstrb = 4'h0;
    bus_q.push_back({32'h0002_0000, 32'h0, 4'h0});
    exp_q.push_back(ack_exp(1'b0, 1'b0, 32'h0002_0000 ^ RD_KEY));
    wait_bus(got, bo); g = cyc; be = bus_q.pop_front();
    n_vec++;
    if (bo !== be) begin n_err++; $display("FAIL defer_bus: got %h exp %h", bo, be); end
    tick();
    dbg_halt = 1'b1;
    tick();
    dbg_halt = 1'b0;
    n_vec++;
    if (cpu_n_reset !== 1'b1) begin n_err++; $display("FAIL defer_in_xfer: got %b exp 1", cpu_n_reset); end
    wait_ack(got, ao, t); ae = exp_q.pop_front();
    n_vec++;
    if (ao !== ae) begin n_err++; $display("FAIL defer_ack: got %h exp %h", ao, ae); end
    n_vec++;
    if (t - g !== 6) begin n_err++; $display("FAIL defer_latency: got %0d exp 6", t - g); end
    cpu_valid = 1'b0;
    n_vec++;
    if (cpu_n_reset !== 1'b1) begin n_err++; $display("FAIL defer_in_ack: got %b exp 1", cpu_n_reset); end
    tick();
    n_vec++;
    if (cpu_n_reset !== 1'b1) begin n_err++; $display("FAIL defer_in_idle: got %b exp 1", cpu_n_reset); end
    tick();
    n_vec++;
    if ({cpu_n_reset, dbg_halted} !== 2'b01) begin
      n_err++; $display("FAIL defer_halted: got %b exp 01", {cpu_n_reset, dbg_halted});
    end
    ready_delay = 0;
  endtask

  task automatic test_halt_reload();
    logic e;
    repeat (2) tick();
    dbg_halt = 1'b1;
    tick();
    dbg_halt = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      e = (k == HOLD);
      n_vec++;
      if ({cpu_n_reset, dbg_halted} !== {e, ~e}) begin
        n_err++;
        $display("FAIL reload edge %0d: got %b exp %b", k, {cpu_n_reset, dbg_halted}, {e, ~e});
      end
    end
  endtask

  task automatic test_dbg_write_halted();
    bit got;
    logic [BUS_W-1:0] bo, be;
    logic [SB_W-1:0] ao, ae;
    int c, t;
    logic [31:0] wa [3];
    logic [31:0] wd [3];
    wa = '{32'h0002_0000, 32'h0002_0004, 32'h0002_0008};
    wd = '{32'h0001_07b7, 32'h0007_a023, 32'h0000_006f};
    dbg_halt = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      dbg_req = 1'b1; dbg_adr = wa[i]; dbg_do = wd[i]; dbg_wren = 4'hF;
      c = cyc;
      bus_q.push_back({wa[i], wd[i], 4'hF});
      exp_q.push_back(ack_exp(1'b1, 1'b0, wa[i] ^ RD_KEY));
      wait_bus(got, bo); be = bus_q.pop_front();
      n_vec++;
      if (bo !== be) begin n_err++; $display("FAIL dbgwr_bus %0d: got %h exp %h", i, bo, be); end
      wait_ack(got, ao, t); ae = exp_q.pop_front();
      n_vec++;
      if (ao !== ae) begin n_err++; $display("FAIL dbgwr_ack %0d: got %h exp %h", i, ao, ae); end
      n_vec++;
      if (t - c !== 2) begin n_err++; $display("FAIL dbgwr_latency %0d: got %0d exp 2", i, t - c); end
      n_vec++;
      if ({bus_valid, cpu_n_reset} !== 2'b00) begin
        n_err++; $display("FAIL dbgwr_state %0d: got %b exp 00", i, {bus_valid, cpu_n_reset});
      end
      dbg_req = 1'b0; dbg_wren = 4'h0;
      tick();
    end
  endtask

  task automatic test_timeout();
    bit got;
    logic [BUS_W-1:0] bo, be;
    logic [SB_W-1:0] ao, ae;
    int c, t;
    ready_never = 1'b1;
    dbg_req = 1'b1; dbg_adr = 32'h0003_0000; dbg_do = 32'hDEAD_BEEF; dbg_wren = 4'h0;
    c = cyc;
    bus_q.push_back({32'h0003_0000, 32'hDEAD_BEEF, 4'h0});
    exp_q.push_back(ack_exp(1'b1, 1'b1, 32'h0));
    wait_bus(got, bo); be = bus_q.pop_front();
    n_vec++;
    if (bo !== be) begin n_err++; $display("FAIL tmo_bus: got %h exp %h", bo, be); end
    wait_ack(got, ao, t); ae = exp_q.pop_front();
    n_vec++;
    if (ao !== ae) begin n_err++; $display("FAIL tmo_ack: got %h exp %h", ao, ae); end
    n_vec++;
    if (t - c !== TMO + 1) begin n_err++; $display("FAIL tmo_window: got %0d exp %0d", t - c, TMO + 1); end
    dbg_req = 1'b0;
    ready_never = 1'b0;
    tick();
    n_vec++;
    if ({bus_err, dbg_ack, bus_valid} !== 3'b000) begin
      n_err++; $display("FAIL tmo_pulse: got %b exp 000", {bus_err, dbg_ack, bus_valid});
    end
  endtask

  task automatic test_async_reset();
    bit got;
    logic [BUS_W-1:0] bo, be;
    dbg_halt = 1'b0;
    repeat (HOLD + 1) tick();
    n_vec++;
    if (cpu_n_reset !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %b exp 1", cpu_n_reset); end
    ready_delay = 8;
    dbg_req = 1'b1; dbg_adr = 32'h0004_0000; dbg_do = 32'h0; dbg_wren = 4'h0;
    bus_q.push_back({32'h0004_0000, 32'h0, 4'h0});
    wait_bus(got, bo); be = bus_q.pop_front();
    n_vec++;
    if (bo !== be) begin n_err++; $display("FAIL arst_bus: got %h exp %h", bo, be); end
    tick();
    #2 n_reset = 1'b0;
    #1;
    n_vec++;
    if ({bus_valid, dbg_ack, cpu_n_reset, dbg_halted} !== 4'b0001) begin
      n_err++;
      $display("FAIL arst_async: got %b exp 0001", {bus_valid, dbg_ack, cpu_n_reset, dbg_halted});
    end
    n_vec++;
    if (bus_addr !== '0) begin n_err++; $display("FAIL arst_addr: got %h exp 0", bus_addr); end
    dbg_req = 1'b0;
    ready_delay = 0;
    tick();
    n_reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [BUS_W-1:0] bo, be;
    logic [SB_W-1:0] ao, ae;
    int t1, t2;
    logic [31:0] ca, cd, da, dd;
    logic [3:0] cs, ds;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (cpu_n_reset === 1'b1) got = 1'b1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL b2b_release: got cpu_n_reset %b exp 1", cpu_n_reset); end
    for (int it = 0; it < 6; it++) begin
      ca = $urandom() & 32'hFFFF_FFFC; cd = $urandom(); cs = 4'($urandom_range(0, 15));
      da = $urandom() & 32'hFFFF_FFFC; dd = $urandom(); ds = 4'($urandom_range(0, 15));
      cpu_valid = 1'b1; cpu_addr = ca; cpu_wdata = cd; cpu_wstrb = cs;
      dbg_req = 1'b1; dbg_adr = da; dbg_do = dd; dbg_wren = ds;
      bus_q.push_back({da, dd, ds});
      bus_q.push_back({ca, cd, cs});
      exp_q.push_back(ack_exp(1'b1, 1'b0, da ^ RD_KEY));
      exp_q.push_back(ack_exp(1'b0, 1'b0, ca ^ RD_KEY));
      wait_bus(got, bo); be = bus_q.pop_front();
      n_vec++;
      if (bo !== be) begin n_err++; $display("FAIL b2b_bus_dbg %0d: got %h exp %h", it, bo, be); end
      wait_ack(got, ao, t1); ae = exp_q.pop_front();
      n_vec++;
      if (ao !== ae) begin n_err++; $display("FAIL b2b_ack_dbg %0d: got %h exp %h", it, ao, ae); end
      dbg_req = 1'b0;
      wait_bus(got, bo); be = bus_q.pop_front();
      n_vec++;
      if (bo !== be) begin n_err++; $display("FAIL b2b_bus_cpu %0d: got %h exp %h", it, bo, be); end
      wait_ack(got, ao, t2); ae = exp_q.pop_front();
      n_vec++;
      if (ao !== ae) begin n_err++; $display("FAIL b2b_ack_cpu %0d: got %h exp %h", it, ao, ae); end
      cpu_valid = 1'b0;
      n_vec++;
      if (t2 - t1 !== 3) begin n_err++; $display("FAIL b2b_spacing %0d: got %0d exp 3", it, t2 - t1); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_arb_priority();
    test_halt_defer();
    test_halt_reload();
    test_dbg_write_halted();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
